// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
// Shared constants for the seven-segment scan controller:
//   - FONT_AL     : 16-entry hex font, active-low, bit order {dp,g,f,e,d,c,b,a}
//   - SEG_OFF_AL  : all-segments-off pattern in active-low form
//   - ST_OFF/ST_SCAN : scan FSM state encoding
package seg_scan_pkg;

  localparam logic [7:0] SEG_OFF_AL = 8'hFF;

  // Entry [n] is the glyph for nibble n; dp (bit 7) is off in every glyph.
  localparam logic [15:0][7:0] FONT_AL = {
    8'h8e, 8'h86, 8'ha1, 8'hc6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hf8, 8'h82, 8'h92, 8'h99, 8'hb0, 8'ha4, 8'hf9, 8'hc0
  };

  localparam logic [0:0] ST_OFF  = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode
// Combinational hex-to-seven-segment decoder producing an active-low pattern.
// Polarity conversion for the board is done by the caller.
// Ports:
//   i_nibble  in  4  hex value to display
//   i_dp      in  1  light the decimal point
//   i_blank   in  1  force every segment (including dp) off
//   o_seg_al  out 8  active-low pattern {dp,g,f,e,d,c,b,a}
module hex7seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg_al
);

  always_comb begin
    o_seg_al = FONT_AL[i_nibble];
    if (i_dp)    o_seg_al[7] = 1'b0;
    if (i_blank) o_seg_al    = SEG_OFF_AL;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Multiplexed seven-segment scan controller running on clk. Each digit owns a
// slot of SCAN_DIV cycles; the first GUARD cycles of a slot drive every digit
// off to suppress ghosting. Display data is captured into shadow registers once
// per frame (and on enable) so mid-frame input changes never tear the display.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
// Ports:
//   clk         in   1            system clock
//   rst         in   1            asynchronous reset, active low
//   en          in   1            display enable, 0 = all digits off
//   data_in     in   4*N_DIGITS   hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in       in   N_DIGITS     per-digit decimal point
//   blank_in    in   N_DIGITS     per-digit forced blank
//   sm_seg      out  8            segment lines {dp,g,f,e,d,c,b,a}
//   sm_bit      out  N_DIGITS     one-hot digit select
//   frame_done  out  1            one-cycle pulse when a snapshot is taken
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 210000,
  parameter int GUARD          = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  output logic [7:0]              sm_seg,
  output logic [N_DIGITS-1:0]     sm_bit,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  // XOR masks converting internal active-low/active-high forms to pin polarity.
  localparam logic [7:0]          SEG_INV  = {8{~SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_INV  = {N_DIGITS{DIG_ACTIVE_LOW}};

  generate
    if (N_DIGITS < 2 || N_DIGITS > 16 || SCAN_DIV < 2 || GUARD < 0 || GUARD >= SCAN_DIV) begin : g_bad_params
      $error("seg_scan_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*N_DIGITS-1:0] r_sh_data;
  logic [N_DIGITS-1:0] r_sh_dp;
  logic [N_DIGITS-1:0] r_sh_blank;
  logic [7:0]          r_sm_seg;
  logic [N_DIGITS-1:0] r_sm_bit;
  logic                r_frame_done;

  logic                w_slot_end;
  logic                w_start;
  logic                w_frame_end;
  logic                w_snap;
  logic                w_in_guard;
  logic                w_show;
  logic [N_DIGITS-1:0] w_lzb;
  logic [3:0]          w_nib;
  logic [7:0]          w_seg_al;
  logic [N_DIGITS-1:0] w_onehot;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_start     = (r_state == ST_OFF) && en;
  // en low in the last cycle of a frame suppresses the snapshot.
  assign w_frame_end = (r_state == ST_SCAN) && en && w_slot_end && (r_idx == IDX_LAST);
  assign w_snap      = w_start || w_frame_end;

  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_in_guard = 1'b0;
    end else begin : g_guard
      assign w_in_guard = (r_cnt < CNT_W'(GUARD));
    end
  endgenerate

`ifdef SEG_SCAN_LZB_EN
  // The blank mask is derived from the values being captured, so it is exactly
  // the mask of the shadow contents for the whole frame.
  logic w_lead;
  always_comb begin
    w_lzb  = '0;
    w_lead = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (data_in[4*i +: 4] != 4'h0 || dp_in[i]) w_lead = 1'b0;
      w_lzb[i] = w_lead;
    end
  end
`else
  assign w_lzb = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (r_state == ST_OFF) begin
      r_cnt <= '0;
      r_idx <= '0;
      if (en) r_state <= ST_SCAN;
    end else if (!en) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_snap;
      if (w_snap) begin
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in | w_lzb;
      end
    end
  end

  assign w_nib    = r_sh_data[{r_idx, 2'b00} +: 4];
  assign w_onehot = N_DIGITS'(1) << r_idx;

  hex7seg_decode u_decode (
    .i_nibble (w_nib),
    .i_dp     (r_sh_dp[r_idx]),
    .i_blank  (r_sh_blank[r_idx]),
    .o_seg_al (w_seg_al)
  );

  // en is included so that dropping enable blanks the pins on the very next edge.
  assign w_show = (r_state == ST_SCAN) && en && !w_in_guard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sm_seg <= SEG_OFF_AL ^ SEG_INV;
      r_sm_bit <= DIG_INV;
    end else if (w_show) begin
      r_sm_seg <= w_seg_al ^ SEG_INV;
      r_sm_bit <= w_onehot ^ DIG_INV;
    end else begin
      r_sm_seg <= SEG_OFF_AL ^ SEG_INV;
      r_sm_bit <= DIG_INV;
    end
  end

  assign sm_seg     = r_sm_seg;
  assign sm_bit     = r_sm_bit;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with N_DIGITS=8, SCAN_DIV=4, GUARD=1. Two instances
// share the stimulus: one with active-low pins, one with active-high pins.
// A behavioural model tracks time since enable and derives slot/phase by
// division; it honours SEG_SCAN_LZB_EN when that macro is defined.
module tb_seg_scan_ctrl;

  localparam int TN    = 8;
  localparam int TSD   = 4;
  localparam int TG    = 1;
  localparam int FRAME = TN * TSD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] data_in  = '0;
  logic [7:0]  dp_in    = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  sm_seg, sm_bit, sm_seg_ah, sm_bit_ah;
  logic        frame_done, frame_done_ah;

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .N_DIGITS(TN), .SCAN_DIV(TSD), .GUARD(TG),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .sm_seg(sm_seg), .sm_bit(sm_bit), .frame_done(frame_done)
  );

  seg_scan_ctrl #(
    .N_DIGITS(TN), .SCAN_DIV(TSD), .GUARD(TG),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_dut_ah (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .sm_seg(sm_seg_ah), .sm_bit(sm_bit_ah), .frame_done(frame_done_ah)
  );

  // ---------------- reference model ----------------
  logic [7:0] font [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};
  bit          m_on    = 1'b0;
  int          m_t     = 0;
  logic [31:0] m_data  = '0;
  logic [7:0]  m_dp    = '0;
  logic [7:0]  m_blank = '0;
  logic [7:0]  e_seg = 8'hFF, e_bit = 8'hFF, e_seg_ah = 8'h00, e_bit_ah = 8'h00;
  logic        e_fd  = 1'b0;

`ifdef SEG_SCAN_LZB_EN
  function automatic logic [7:0] lzb_mask(input logic [31:0] d, input logic [7:0] p);
    logic [7:0] m;
    m = '0;
    for (int i = TN - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'h0 || p[i]) break;
      m[i] = 1'b1;
    end
    return m;
  endfunction
`endif

  task automatic snap();
    m_data  = data_in;
    m_dp    = dp_in;
    m_blank = blank_in;
`ifdef SEG_SCAN_LZB_EN
    m_blank = m_blank | lzb_mask(data_in, dp_in);
`endif
  endtask

  function automatic logic [7:0] glyph(input int d);
    logic [7:0] s;
    if (m_blank[d]) return 8'hFF;
    s = font[m_data[4*d +: 4]];
    if (m_dp[d]) s[7] = 1'b0;
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_on = 1'b0; m_t = 0; m_data = '0; m_dp = '0; m_blank = '0;
      e_seg = 8'hFF; e_bit = 8'hFF; e_fd = 1'b0;
    end else begin
      if (m_on && en && (m_t % TSD) >= TG) begin
        e_seg = glyph((m_t / TSD) % TN);
        e_bit = ~(8'h01 << ((m_t / TSD) % TN));
      end else begin
        e_seg = 8'hFF;
        e_bit = 8'hFF;
      end
      e_fd = 1'b0;
      if (!m_on) begin
        if (en) begin
          m_on = 1'b1; m_t = 0; snap(); e_fd = 1'b1;
        end
      end else if (!en) begin
        m_on = 1'b0;
      end else begin
        if (m_t % FRAME == FRAME - 1) begin
          snap(); e_fd = 1'b1;
        end
        m_t++;
      end
    end
    e_seg_ah = ~e_seg;
    e_bit_ah = ~e_bit;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_disp(input string nm, input logic [7:0] s, input logic [7:0] b);
    logic [7:0] si, bi;
    si = ~s;
    bi = ~b;
    chk({nm, "_seg"},    sm_seg,    s);
    chk({nm, "_bit"},    sm_bit,    b);
    chk({nm, "_seg_ah"}, sm_seg_ah, si);
    chk({nm, "_bit_ah"}, sm_bit_ah, bi);
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      chk("sb_seg",    sm_seg,        e_seg);
      chk("sb_bit",    sm_bit,        e_bit);
      chk("sb_fd",     frame_done,    e_fd);
      chk("sb_seg_ah", sm_seg_ah,     e_seg_ah);
      chk("sb_bit_ah", sm_bit_ah,     e_bit_ah);
      chk("sb_fd_ah",  frame_done_ah, e_fd);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [63:0] segs;   // active-low glyph of digit d at [8d +: 8]
  } vec_t;
  vec_t vecs [6];

  initial begin
`ifdef SEG_SCAN_LZB_EN
    vecs[0] = '{32'h01234567, 8'h00, 8'h00, 64'hFFF9A4B0999282F8};
    vecs[3] = '{32'h000000A5, 8'h00, 8'h00, 64'hFFFFFFFFFFFF8892};
    vecs[4] = '{32'h000000A5, 8'h08, 8'h00, 64'hFFFFFFFF40C08892};
`else
    vecs[0] = '{32'h01234567, 8'h00, 8'h00, 64'hC0F9A4B0999282F8};
    vecs[3] = '{32'h000000A5, 8'h00, 8'h00, 64'hC0C0C0C0C0C08892};
    vecs[4] = '{32'h000000A5, 8'h08, 8'h00, 64'hC0C0C0C040C08892};
`endif
    vecs[1] = '{32'h89ABCDEF, 8'h01, 8'h00, 64'h80908883C6A1860E};
    vecs[2] = '{32'h76543210, 8'hA0, 8'h0C, 64'h78821299FFFFF9C0};
    vecs[5] = '{32'h12345678, 8'h01, 8'h00, 64'hF9A4B0999282F800};

    // Reset held with en high and arbitrary data.
    en = 1'b1;
    data_in = 32'hDEADBEEF;
    dp_in = 8'h5A;
    #1 rst = 1'b0;
    sb_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_disp("reset", 8'hFF, 8'hFF);
      chk("reset_fd", frame_done, 1'b0);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors: enable from OFF, check each digit mid-slot.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      data_in = vecs[v].data; dp_in = vecs[v].dp; blank_in = vecs[v].blank;
      en = 1'b1;
      for (int d = 0; d < TN; d++) begin
        repeat (4) @(negedge clk);
        chk_disp($sformatf("vec%0d_dig%0d", v, d), vecs[v].segs[8*d +: 8], ~(8'h01 << d));
      end
    end

    // Mid-frame data change does not reach the display until the next frame.
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    data_in = 32'h01234567; dp_in = '0; blank_in = '0; en = 1'b1;
    @(negedge clk);
    chk("enable_fd", frame_done, 1'b1);
    @(negedge clk);
    chk_disp("guard_dig0", 8'hFF, 8'hFF);
    repeat (14) @(negedge clk);
    chk_disp("pre_change_dig3", 8'h99, 8'hF7);
    data_in = 32'hFFFFFFFF;
    repeat (4) @(negedge clk);
    chk_disp("old_dig4", 8'hB0, 8'hEF);
    repeat (13) @(negedge clk);
    chk("frame_fd", frame_done, 1'b1);
    repeat (3) @(negedge clk);
    chk_disp("new_dig0", 8'h8E, 8'hFE);

    // Enable dropped mid-slot, then re-enabled with new data.
    en = 1'b0;
    @(negedge clk);
    chk_disp("en_off", 8'hFF, 8'hFF);
    data_in = 32'h89ABCDE1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_fd", frame_done, 1'b1);
    repeat (3) @(negedge clk);
    chk_disp("reen_dig0", 8'hF9, 8'hFE);

    // en falls in the snapshot cycle: no frame_done, outputs off.
    repeat (28) @(negedge clk);
    en = 1'b0;
    data_in = 32'h22222222;
    @(negedge clk);
    chk("enfall_snap_fd", frame_done, 1'b0);
    chk_disp("enfall_snap_off", 8'hFF, 8'hFF);

    // Randomised run against the model, including one async reset pulse.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 2000) begin #1 rst = 1'b0; end
      if (i == 2003) begin #1 rst = 1'b1; end
      if (en) begin
        if ($urandom_range(0, 149) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        data_in  = $urandom >> $urandom_range(0, 31);
        dp_in    = 8'($urandom & $urandom & $urandom);
        blank_in = 8'($urandom & $urandom & $urandom);
      end
    end

    @(negedge clk);
    sb_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment scan controller for the board display.
- Replaces the fixed 8-digit, derived-clock scanner in the top level. Runs on clk with a clock-enable tick instead of a generated clock.
- Adds frame-coherent data snapshot, anti-ghost guard time, per-digit decimal point/blanking, polarity selection and an enable input.
- Sits between the packet/blink analysis outputs and the sm_seg/sm_bit pins.

Parameters:
- N_DIGITS, 8, number of multiplexed digits (2..16).
- SCAN_DIV, 210000, clk cycles per digit slot (>= 2).
- GUARD, 1024, cycles at slot start with all digits off (0 <= GUARD < SCAN_DIV).
- SEG_ACTIVE_LOW, 1, 1 = segment lines active low (common anode).
- DIG_ACTIVE_LOW, 1, 1 = digit select lines active low.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  display enable; 0 = all off.
- data_in  in  4*N_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost).
- dp_in  in  N_DIGITS  decimal point on per digit.
- blank_in  in  N_DIGITS  force digit's segments off.
- sm_seg  out  8  segments {dp,g,f,e,d,c,b,a}.
- sm_bit  out  N_DIGITS  one-hot digit select.
- frame_done  out  1  one-cycle pulse at each frame snapshot.

Behaviour:
- Reset: clk and rst are fixed as above. Reset state: FSM = OFF, cnt = 0, idx = 0, shadow regs = 0, frame_done = 0. sm_seg and sm_bit are all inactive: 8'hFF / all ones when active low, else all zeros.
- FSM has two states, OFF and SCAN.
  - OFF -> SCAN when en = 1.
  - SCAN -> OFF when en = 0, in any cycle, mid-slot allowed.
- In OFF: cnt and idx are held at 0 and outputs are inactive on the next edge.
- SCAN counter: cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx increments.
  - idx wraps from N_DIGITS-1 to 0.
- Snapshot: data_in, dp_in and blank_in are loaded into shadow regs in exactly two cases:
  - on the OFF->SCAN transition;
  - in the cycle cnt = SCAN_DIV-1 with idx = N_DIGITS-1.
  frame_done pulses in that same edge (registered). Input changes mid-frame never reach the display before the next snapshot.
- Outputs are registered, 1 cycle latency from (state, cnt, idx):
  - cnt < GUARD: sm_bit all inactive, sm_seg all inactive.
  - cnt >= GUARD: sm_bit[idx] active, others inactive. sm_seg = font(shadow nibble idx), with dp active if shadow dp[idx]; all segments inactive if shadow blank[idx].
- Font, active-low, nibbles 0..F: c0, f9, a4, b0, 99, 92, 82, f8, 80, 90, 88, 83, c6, a1, 86, 8e (bit7 = dp, 1 = off).
- SEG_ACTIVE_LOW = 0 inverts all 8 segment bits. DIG_ACTIVE_LOW = 0 inverts sm_bit.
- Frame period = N_DIGITS*SCAN_DIV cycles. First slot after enable is digit 0 with a full guard period.
- Simultaneous en fall and snapshot cycle: en wins, no snapshot, no frame_done.
- Illegal parameters (GUARD >= SCAN_DIV, N_DIGITS < 2) are rejected by elaboration-time check.

Optional Feature:
- Macro SEG_SCAN_LZB_EN enables leading-zero blanking, computed on shadow regs at snapshot.
  - Walking down from digit N_DIGITS-1, each digit whose nibble = 0 and dp = 0 is blanked.
  - The walk stops at the first nonzero nibble or set dp.
  - Digit 0 is never blanked.
- Without the macro, all digits display their nibble (zeros show "0").

Decomposition:
- Package seg_scan_pkg holds:
  - the 16-entry active-low font constant;
  - SEG_OFF_AL = 8'hFF;
  - the FSM state encoding (OFF, SCAN).
- Sub-module hex7seg_decode: nibble, dp and blank in -> 8-bit active-low pattern out. Combinational; instantiated once, muxed by idx. Polarity inversion stays in seg_scan_ctrl.

Test Plan:
1. rst low with en = 1 and arbitrary data -> sm_seg = 8'hFF, sm_bit = 8'hFF, frame_done = 0 throughout reset.
2. N = 8, SCAN_DIV = 4, GUARD = 1, data_in = 32'h01234567, en = 1 -> each 4-cycle slot gives 1 cycle all-off, then 3 cycles of:
   - digit 0: 8'hf8 / 8'hfe;
   - digit 1: 8'h82 / 8'hfd;
   - ... up to digit 7: 8'hc0 / 8'h7f.
   frame_done pulses every 32 cycles.
3. Change data_in to 32'hFFFFFFFF at idx = 3 -> remaining digits of the frame still show old values; next frame shows 8'h8e on all digits.
4. Deassert en mid-slot -> all outputs inactive next cycle. Reassert -> frame_done pulse, digit 0 slot first, new data shown.
5. data_in = 32'h000000A5, dp_in = 0 -> with SEG_SCAN_LZB_EN, digits 2..7 = 8'hFF; without, they show 8'hc0. With dp_in[3] = 1 and the macro, digits 4..7 are blank and digit 3 shows 8'h40.
6. SEG_ACTIVE_LOW = 0, DIG_ACTIVE_LOW = 0, digit 0 = 4'h8 with dp -> sm_seg = 8'hFF, sm_bit = 8'h01. Same digit without dp -> sm_seg = 8'h7F.
